fnd_time_display: RTL
=====================

# fnd_time_display

Display-side consumer of the watch time bus: takes the msec/sec/min/hour fields and the edit-position select, converts them to decimal digits, and drives a 4-digit multiplexed 7-segment display (FND). It also blinks the field currently being edited. It sits between the watch block and the board's FND pins, and it owns all digit scanning and blink timing.

## Interface
- CLK_HZ, 100_000_000, system clock frequency in Hz
- SCAN_HZ, 1000, digit-advance rate; SCAN_DIV = CLK_HZ/SCAN_HZ cycles per digit
- BLINK_HZ, 2, blink rate; BLINK_DIV = CLK_HZ/(2*BLINK_HZ) cycles per blink half-period
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- mode  in  1  0 = sec:msec view, 1 = hour:min view
- pos_sel  in  3  edit field: 1 = msec, 2 = sec, 3 = min, 4 = hour, 0 or 5-7 = none
- msec  in  7  centiseconds, nominal 0-99
- sec  in  6  seconds, nominal 0-59
- min  in  6  minutes, nominal 0-59
- hour  in  5  hours, nominal 0-23
- fnd_com  out  4  digit enables, active-low, bit0 = rightmost
- fnd_data  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}

## Operation
- Scan counter: runs 0..SCAN_DIV-1. On the terminal count it wraps to 0 and advances the 2-bit digit index 0→1→2→3→0.
- Digit sources:
  - mode 0: idx0 = msec%10, idx1 = (msec/10)%10, idx2 = sec%10, idx3 = (sec/10)%10.
  - mode 1: idx0 = min%10, idx1 = (min/10)%10, idx2 = hour%10, idx3 = (hour/10)%10.
- Out-of-range inputs are not clamped. The mod-10 rule applies as written; for example, msec = 127 shows "27".
- Segment codes for 0-9, dp off: C0 F9 A4 B0 99 92 82 F8 80 90.
- Decimal point: lit (bit7 = 0) only on idx2.
  - mode 0: lit while msec < 50.
  - mode 1: lit while blink phase = 1.
- Blink phase register:
  - Toggles every BLINK_DIV cycles.
  - If the field selected by pos_sel is displayed in the current mode and phase = 0, that field's two digits output fnd_data = 8'hFF. fnd_com still scans normally.
  - A field not displayed in the current mode is never blanked.
- Any change of pos_sel (compared with its registered value from the previous cycle) clears the blink counter and forces phase = 1, so a newly selected field is shown immediately.
- mode changes take effect on the next registered output. Scan state is not reset.

## Timing
- fnd_com and fnd_data are registered. They reflect the digit index and inputs from the previous cycle (1-cycle latency).
- Reset values:
  - fnd_com = 4'hF, fnd_data = 8'hFF
  - digit index = 0, scan and blink counters = 0, blink phase = 1, registered pos_sel = 0
- First cycle after rst deasserts: fnd_com = 4'b1110.
- Each digit is held exactly SCAN_DIV cycles. A full frame is 4*SCAN_DIV cycles.
- Blink half-period is exactly BLINK_DIV cycles, measured from reset or from the last pos_sel change.
- rst asserted mid-scan: outputs blank on the next edge and all state returns to reset values. This takes priority over pos_sel-change restart.
- Scan terminal count and blink terminal count on the same cycle: both take effect independently.

## Configuration
- FND_BLINK_EN defined:
  - Blink counter, phase register and pos_sel edge detection are compiled in.
  - Blanking and the mode-1 blinking dp behave as described above.
- FND_BLINK_EN undefined:
  - pos_sel is ignored and no digit is ever blanked.
  - Blink logic is absent; the phase is treated as constant 1, so the mode-1 dp is steadily lit.

## Test plan
Params for all tests: CLK_HZ = 100, SCAN_HZ = 10, BLINK_HZ = 5, giving SCAN_DIV = 10 and BLINK_DIV = 10. FND_BLINK_EN is defined unless stated.
- Reset: hold rst 3 cycles → fnd_com = F, fnd_data = FF; first cycle after release fnd_com = E, and it stays E for 10 cycles, then D.
- mode 0, sec = 42, msec = 7, pos_sel = 0 → over one frame (com, data) = (E, F8), (D, C0), (B, 24), (7, 99). With msec = 57, the idx2 data becomes A4.
- mode 1, hour = 23, min = 59, pos_sel = 0 → (E, 90), (D, 92), (B, B0/30 following blink phase), (7, A4). Scan wraps 7 → E every 40 cycles.
- mode 1, min = 59, pos_sel = 3 → idx0/idx1 data alternates normal / FF every 10 cycles while fnd_com keeps scanning. Changing pos_sel to 4 mid-blank → hour digits visible on the next registered output, blanked 10 cycles later. min digits are no longer blanked.
- mode 0, pos_sel = 4 (hour, not displayed) → no digit ever blanked over 100 cycles.
- msec = 127 in mode 0 → idx1 = A4, idx0 = F8. Rebuild without FND_BLINK_EN and pos_sel = 1 → no FF data is observed on any displayed digit.

Source files
------------

// File: rtl/fnd_time_display_if.sv
// Watch time bus plus FND pin bundle shared by the watch block (master)
// and the display scanner (slave).
interface fnd_time_display_if;
    logic       mode;
    logic [2:0] pos_sel;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;

    modport master (
        output mode, pos_sel, msec, sec, min, hour,
        input  fnd_com, fnd_data
    );

    modport slave (
        input  mode, pos_sel, msec, sec, min, hour,
        output fnd_com, fnd_data
    );
endinterface

// File: rtl/fnd_time_display.sv
// 4-digit multiplexed 7-segment driver for the watch time bus, with edit-field blink.
// Optional macro FND_BLINK_EN compiles in the blink counter / phase / pos_sel restart.
module fnd_time_display #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2
) (
    input logic               clk,
    input logic               rst,
    fnd_time_display_if.slave bus
);
    localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [SW-1:0] scan_cnt;
    logic [1:0]    dig_idx;
    logic          phase_eff;

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            dig_idx  <= dig_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

`ifdef FND_BLINK_EN
    logic [BW-1:0] blink_cnt;
    logic          phase;
    logic [2:0]    pos_q;
    logic          pos_chg;

    assign pos_chg   = (bus.pos_sel != pos_q);
    // A freshly selected field is shown on the very edge that sees the change.
    assign phase_eff = phase | pos_chg;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
            pos_q     <= '0;
        end else begin
            pos_q <= bus.pos_sel;
            if (pos_chg) begin
                // The change edge itself is the first cycle of the new visible half-period.
                blink_cnt <= (BLINK_DIV > 1) ? BW'(1) : '0;
                phase     <= 1'b1;
            end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`else
    assign phase_eff = 1'b1;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    logic [6:0] lo_val, hi_val, fld_val;
    logic [3:0] digit;
    logic [2:0] fld_id;
    logic       blank, dp_on;

    always_comb begin
        lo_val  = bus.mode ? 7'(bus.min)  : bus.msec;
        hi_val  = bus.mode ? 7'(bus.hour) : 7'(bus.sec);
        fld_val = dig_idx[1] ? hi_val : lo_val;
        digit   = dig_idx[0] ? 4'((fld_val / 7'd10) % 7'd10) : 4'(fld_val % 7'd10);
        // Field ids line up with pos_sel encoding: 1 msec, 2 sec, 3 min, 4 hour.
        fld_id  = 3'({bus.mode, dig_idx[1]}) + 3'd1;
`ifdef FND_BLINK_EN
        blank   = !phase_eff && (bus.pos_sel == fld_id);
`else
        blank   = 1'b0;
`endif
        dp_on   = (dig_idx == 2'd2) && (bus.mode ? phase_eff : (bus.msec < 7'd50));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.fnd_com  <= 4'hF;
            bus.fnd_data <= 8'hFF;
        end else begin
            bus.fnd_com  <= ~(4'b0001 << dig_idx);
            bus.fnd_data <= blank ? 8'hFF : {~dp_on, seg7(digit)};
        end
    end
endmodule
